prll_bs_drvr_fifo: RTL and testbench

//  Per-terminal transmit FIFO feeding one driver port of the parallel bus

---
 rtl/prll_bs_drvr_fifo.sv | 121 ++++++++++++
 tb/tb_prll_bs_drvr_fifo.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/prll_bs_drvr_fifo.sv
// Per-terminal transmit FIFO for one bus driver port. The device pushes words in,
// and the bus pops them when granted. Reads are first-word-fall-through from a
// registered head word. The terminal ID can be stamped into the source field,
// and overflowed writes are counted with saturation.
module prll_bs_drvr_fifo #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned DEPTH     = 16,
    parameter logic [7:0]  ID        = 8'h00,
    parameter int unsigned STAMP_SRC = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [BITS-1:0]          wr_data,
    output logic                     full,
    input  logic                     pop,
    output logic                     pndng,
    output logic [BITS-1:0]          D_pop,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [BITS-1:0] mem_q [DEPTH];

    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     drop_q, drop_d;
    logic            pndng_q, pndng_d;
    logic            full_q, full_d;
    logic [BITS-1:0] head_q, head_d;

    logic [BITS-1:0] wr_word_c;
    logic            pop_acc_c;
    logic            wr_acc_c;

    // Word as it will be stored, with the source field optionally replaced by ID
    always_comb begin
        wr_word_c = wr_data;
        if (STAMP_SRC != 0) begin
            wr_word_c[BITS-9:BITS-16] = ID;
        end
    end

    // Acceptance: a pop frees a slot on the same edge, so full + pop still takes the write
    assign pop_acc_c = pop && (count_q != '0);
    assign wr_acc_c  = wr_en && ((count_q < CW'(DEPTH)) || pop_acc_c);

    // Next-state for pointers, occupancy, flags, drop counter and head word
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        pndng_d  = pndng_q;
        full_d   = full_q;
        head_d   = head_q;

        if (wr_acc_c) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_acc_c) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(wr_acc_c) - CW'(pop_acc_c);

        if (wr_en && !wr_acc_c && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end

        pndng_d = (count_d != '0);
        full_d  = (count_d == CW'(DEPTH));

        // The new write becomes the head when nothing older remains after this edge
        if (count_d == '0) begin
            head_d = '0;
        end else if (wr_acc_c && (count_q == CW'(pop_acc_c))) begin
            head_d = wr_word_c;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Control state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            pndng_q  <= 1'b0;
            full_q   <= 1'b0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            pndng_q  <= pndng_d;
            full_q   <= full_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_acc_c) begin
            mem_q[wr_ptr_q] <= wr_word_c;
        end
    end

    assign full     = full_q;
    assign pndng    = pndng_q;
    assign D_pop    = head_q;
    assign count    = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_prll_bs_drvr_fifo.sv
// Self-checking bench for prll_bs_drvr_fifo against a queue-based reference model.
module tb_prll_bs_drvr_fifo;

    localparam int unsigned BITS  = 32;
    localparam int unsigned DEPTH = 16;
    localparam logic [7:0]  ID    = 8'h00;

    logic            clk;
    logic            reset;
    logic            wr_en;
    logic [31:0]     wr_data;
    logic            full;
    logic            pop;
    logic            pndng;
    logic [31:0]     D_pop;
    logic [4:0]      count;
    logic [15:0]     drop_cnt;

    int checks;
    int errors;

    logic [31:0] q [$];
    int          mdrop;

    prll_bs_drvr_fifo #(
        .BITS(BITS), .DEPTH(DEPTH), .ID(ID), .STAMP_SRC(1)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .full(full),
        .pop(pop), .pndng(pndng), .D_pop(D_pop), .count(count), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] stamp(input logic [31:0] d);
        return {d[31:24], ID, d[15:0]};
    endfunction

    // Compare every output against the reference queue
    task automatic check_model(input string tag);
        chk({tag, ".pndng"}, 32'(pndng), 32'(q.size() != 0));
        chk({tag, ".count"}, 32'(count), 32'(q.size()));
        chk({tag, ".full"},  32'(full),  32'(q.size() == DEPTH));
        chk({tag, ".drop"},  32'(drop_cnt), 32'(mdrop));
        if (q.size() != 0) chk({tag, ".dpop"}, D_pop, q[0]);
    endtask

    // One clock: drive at posedge+1, model the edge, check at next posedge+1
    task automatic cyc(input logic w, input logic [31:0] d, input logic p, input bit do_chk);
        bit pa, wa;
        wr_en = w; wr_data = d; pop = p;
        @(posedge clk);
        pa = p && (q.size() != 0);
        wa = w && ((q.size() < DEPTH) || pa);
        if (pa) void'(q.pop_front());
        if (wa) q.push_back(stamp(d));
        else if (w && mdrop < 65535) mdrop++;
        #1;
        wr_en = 1'b0; pop = 1'b0;
        if (do_chk) check_model("step");
    endtask

    initial begin
        checks = 0; errors = 0; mdrop = 0;
        reset = 1'b0; wr_en = 1'b0; wr_data = '0; pop = 1'b0;

        // Reset state
        #12;
        chk("rst.pndng", 32'(pndng), 32'd0);
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.full",  32'(full),  32'd0);
        chk("rst.drop",  32'(drop_cnt), 32'd0);
        chk("rst.dpop",  D_pop, 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;

        // Single word with source stamping, then pop
        cyc(1'b1, 32'h0105_0007, 1'b0, 1'b1);
        chk("single.dpop", D_pop, 32'h0100_0007);
        chk("single.pndng", 32'(pndng), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("single.empty", 32'(pndng), 32'd0);
        chk("single.count", 32'(count), 32'd0);

        // Fill, overflow three, drain in order
        for (int i = 0; i < 16; i++) cyc(1'b1, {8'h20 + 8'(i), 8'h77, 16'(i)}, 1'b0, 1'b1);
        chk("fill.full", 32'(full), 32'd1);
        chk("fill.count", 32'(count), 32'd16);
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("ovf.drop", 32'(drop_cnt), 32'd3);
        for (int i = 0; i < 16; i++) begin
            chk("drain.order", 32'(D_pop[15:0]), 32'(i));
            cyc(1'b0, '0, 1'b1, 1'b1);
        end
        chk("drain.pndng", 32'(pndng), 32'd0);

        // Simultaneous write and pop while full
        for (int i = 0; i < 16; i++) cyc(1'b1, {8'h30, 8'h11, 16'(i)}, 1'b0, 1'b1);
        cyc(1'b1, {8'h31, 8'h22, 16'hAAAA}, 1'b1, 1'b1);
        chk("both.count", 32'(count), 32'd16);
        chk("both.full",  32'(full),  32'd1);
        chk("both.drop",  32'(drop_cnt), 32'd3);
        for (int i = 0; i < 15; i++) cyc(1'b0, '0, 1'b1, 1'b1);
        chk("both.last", D_pop, {8'h31, ID, 16'hAAAA});
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("both.empty", 32'(pndng), 32'd0);

        // Empty + write + pop: pop ignored, write lands
        cyc(1'b1, 32'h4455_6677, 1'b1, 1'b1);
        chk("emptyboth.count", 32'(count), 32'd1);
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Random traffic across pointer wrap
        for (int i = 0; i < 1000; i++) begin
            logic w, p;
            w = ($urandom_range(0, 99) < 55);
            p = pndng && ($urandom_range(0, 99) < 45);
            cyc(w, $urandom, p, 1'b1);
        end
        while (q.size() != 0) cyc(1'b0, '0, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        chk("popempty.count", 32'(count), 32'd0);

        // Reset in the middle of traffic
        for (int i = 0; i < 5; i++) cyc(1'b1, $urandom, 1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("midrst.pndng", 32'(pndng), 32'd0);
        chk("midrst.count", 32'(count), 32'd0);
        chk("midrst.drop",  32'(drop_cnt), 32'd0);
        q.delete(); mdrop = 0;
        pop = 1'b1;
        @(posedge clk); #1;
        pop = 1'b0;
        chk("midrst.hold", 32'(count), 32'd0);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        cyc(1'b1, 32'h0AFF_1234, 1'b0, 1'b1);
        chk("midrst.first", D_pop, 32'h0A00_1234);
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Drop counter saturation
        for (int i = 0; i < 16; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) cyc(1'b1, $urandom, 1'b0, 1'b0);
        check_model("sat");
        chk("sat.drop", 32'(drop_cnt), 32'h0000_FFFF);
        cyc(1'b1, $urandom, 1'b0, 1'b1);
        chk("sat.hold", 32'(drop_cnt), 32'h0000_FFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
